// File: rtl/ram_march_tester.sv
// March C- built-in self-test engine for a single-port RAM (async read, sync write).
// Drives the RAM port while busy and records the first failing address, data and element.
module ram_march_tester #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] BG_PATTERN = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_data,
   output logic [2:0]            fail_elem,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_wr_en,
   input  logic [DATA_WIDTH-1:0] ram_data_out
);

   // state  | meaning
   // IDLE   | after reset, waiting for start, RAM port parked at zero
   // RUN    | one march op per cycle; op held in elem/addr/rd registers
   // DONE   | result valid, waiting for next start

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   state_t                  state_q, state_d;
   logic [2:0]              elem_q, elem_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    rd_q, rd_d;
   logic                    busy_q, busy_d;
   logic                    wr_en_q, wr_en_d;
   logic [DATA_WIDTH-1:0]   data_in_q, data_in_d;
   logic                    done_q, done_d;
   logic                    pass_q, pass_d;
   logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
   logic [DATA_WIDTH-1:0]   fail_data_q, fail_data_d;
   logic [2:0]              fail_elem_q, fail_elem_d;

   logic [2:0]              elem_nx;
   logic                    last_addr;
   logic                    mismatch;

   function automatic logic elem_down(input logic [2:0] e);
      return (e == 3'd3) || (e == 3'd4);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] elem_wval(input logic [2:0] e);
      return ((e == 3'd1) || (e == 3'd3)) ? ~BG_PATTERN : BG_PATTERN;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] elem_rval(input logic [2:0] e);
      return ((e == 3'd2) || (e == 3'd4)) ? ~BG_PATTERN : BG_PATTERN;
   endfunction

   assign elem_nx   = elem_q + 3'd1;
   assign last_addr = elem_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_LAST);
   assign mismatch  = busy_q && rd_q && (ram_data_out != elem_rval(elem_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         elem_q      <= 3'd0;
         addr_q      <= '0;
         rd_q        <= 1'b0;
         busy_q      <= 1'b0;
         wr_en_q     <= 1'b0;
         data_in_q   <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         fail_elem_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         addr_q      <= addr_d;
         rd_q        <= rd_d;
         busy_q      <= busy_d;
         wr_en_q     <= wr_en_d;
         data_in_q   <= data_in_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
         fail_elem_q <= fail_elem_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      addr_d      = addr_q;
      rd_d        = rd_q;
      busy_d      = busy_q;
      wr_en_d     = wr_en_q;
      data_in_d   = data_in_q;
      done_d      = done_q;
      pass_d      = pass_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      fail_elem_d = fail_elem_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_RUN;
               busy_d      = 1'b1;
               elem_d      = 3'd0;
               addr_d      = '0;
               rd_d        = 1'b0;
               wr_en_d     = 1'b1;
               data_in_d   = BG_PATTERN;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               fail_addr_d = '0;
               fail_data_d = '0;
               fail_elem_d = 3'd0;
            end
         end
         S_RUN: begin
            if (mismatch || (last_addr && !rd_q && elem_q == 3'd5) ||
                (last_addr && rd_q && elem_q == 3'd5)) begin
               // abort on mismatch, or finish after the final M5 read
               state_d   = S_DONE;
               busy_d    = 1'b0;
               elem_d    = 3'd0;
               addr_d    = '0;
               rd_d      = 1'b0;
               wr_en_d   = 1'b0;
               data_in_d = '0;
               done_d    = 1'b1;
               pass_d    = !mismatch;
               if (mismatch) begin
                  fail_addr_d = addr_q;
                  fail_data_d = ram_data_out;
                  fail_elem_d = elem_q;
               end
            end else if (rd_q && elem_q != 3'd5) begin
               rd_d      = 1'b0;
               wr_en_d   = 1'b1;
               data_in_d = elem_wval(elem_q);
            end else if (!last_addr) begin
               addr_d    = elem_down(elem_q) ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
               rd_d      = (elem_q != 3'd0);
               wr_en_d   = (elem_q == 3'd0);
               data_in_d = (elem_q == 3'd0) ? BG_PATTERN : '0;
            end else begin
               elem_d    = elem_nx;
               addr_d    = elem_down(elem_nx) ? ADDR_LAST : '0;
               rd_d      = 1'b1;
               wr_en_d   = 1'b0;
               data_in_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign fail_addr   = fail_addr_q;
   assign fail_data   = fail_data_q;
   assign fail_elem   = fail_elem_q;
   assign ram_addr    = addr_q;
   assign ram_data_in = data_in_q;
   assign ram_wr_en   = wr_en_q;

endmodule

// File: tb/tb_ram_march_tester.sv
// Bench for ram_march_tester: behavioural RAM with a programmable stuck bit, and a
// reference op list built from the March C- element table.
module tb_ram_march_tester;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int N  = 16;
   localparam logic [DW-1:0] BG = 8'h00;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, pass, ram_wr_en;
   logic [AW-1:0] fail_addr, ram_addr;
   logic [DW-1:0] fail_data, ram_data_in, ram_data_out;
   logic [2:0]    fail_elem;

   logic [DW-1:0] mem [N];
   logic          fault_en = 1'b0;
   int            fault_addr = 0;
   int            fault_bit = 0;
   logic          fault_val = 1'b0;

   int total = 0;
   int bad = 0;

   typedef struct {
      int            addr;
      bit            wr;
      logic [DW-1:0] data;
      int            elem;
   } op_t;
   op_t ops[$];

   ram_march_tester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BG_PATTERN(BG)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
      .fail_addr(fail_addr), .fail_data(fail_data), .fail_elem(fail_elem),
      .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_wr_en(ram_wr_en),
      .ram_data_out(ram_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (ram_wr_en) mem[ram_addr] <= ram_data_in;

   always_comb begin
      ram_data_out = mem[ram_addr];
      if (fault_en && ram_addr == fault_addr[AW-1:0]) ram_data_out[fault_bit] = fault_val;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // March C- table: direction (1=down), read value, write value (-1 none, 0 = B, 1 = ~B)
   task automatic build_ops();
      int el_down[6] = '{0, 0, 0, 1, 1, 0};
      int el_rd[6]   = '{-1, 0, 1, 0, 1, 0};
      int el_wr[6]   = '{0, 1, 0, 1, 0, -1};
      ops.delete();
      for (int e = 0; e < 6; e++)
         for (int j = 0; j < N; j++) begin
            int a = el_down[e] ? N - 1 - j : j;
            if (el_rd[e] >= 0) ops.push_back('{addr: a, wr: 1'b0, data: (el_rd[e] != 0) ? ~BG : BG, elem: e});
            if (el_wr[e] >= 0) ops.push_back('{addr: a, wr: 1'b1, data: (el_wr[e] != 0) ? ~BG : BG, elem: e});
         end
   endtask

   function automatic int predict(output logic [DW-1:0] fd);
      logic [DW-1:0] mm [N];
      logic [DW-1:0] obs;
      fd = '0;
      for (int i = 0; i < ops.size(); i++) begin
         if (ops[i].wr) mm[ops[i].addr] = ops[i].data;
         else begin
            obs = mm[ops[i].addr];
            if (fault_en && ops[i].addr == fault_addr) obs[fault_bit] = fault_val;
            if (obs != ops[i].data) begin
               fd = obs;
               return i;
            end
         end
      end
      return -1;
   endfunction

   task automatic check_idle(input string tag);
      check(tag, {busy, done, pass, fail_addr, fail_data, fail_elem, ram_addr, ram_data_in, ram_wr_en}, '0);
   endtask

   task automatic run_test(input bit hold_start, input int poke_cyc);
      logic [DW-1:0] fd;
      logic [AW-1:0] fa;
      logic [2:0]    fe;
      int k, len;
      k   = predict(fd);
      len = (k < 0) ? ops.size() : k + 1;
      fa  = (k < 0) ? '0 : AW'(ops[k].addr);
      fe  = (k < 0) ? '0 : 3'(ops[k].elem);
      @(negedge clk) start = 1'b1;
      for (int c = 1; c <= len; c++) begin
         @(negedge clk);
         if (!hold_start && c == 1) start = 1'b0;
         if (poke_cyc > 1 && poke_cyc < len - 2) begin
            if (c == poke_cyc) start = 1'b1;
            if (c == poke_cyc + 1) start = 1'b0;
         end
         check("op", {busy, ram_wr_en, ram_addr, ram_data_in},
               {1'b1, ops[c-1].wr, AW'(ops[c-1].addr), ops[c-1].wr ? ops[c-1].data : 8'h00});
         if (c == 1) check("clear", {done, pass, fail_addr, fail_data, fail_elem}, '0);
      end
      @(negedge clk);
      check("result", {busy, ram_wr_en, ram_addr, ram_data_in, done, pass, fail_addr, fail_data, fail_elem},
            {1'b0, 1'b0, 4'h0, 8'h00, 1'b1, (k < 0), fa, fd, fe});
      if (hold_start) begin
         @(negedge clk);
         check("retrig", {busy, done, ram_wr_en, ram_addr, ram_data_in}, {1'b1, 1'b0, 1'b1, 4'h0, BG});
         start = 1'b0;
         #2 rst_n = 1'b0;
         @(negedge clk) rst_n = 1'b1;
      end else begin
         repeat (2) @(negedge clk);
         check("hold", {busy, ram_wr_en, ram_addr, done, pass}, {1'b0, 1'b0, 4'h0, 1'b1, (k < 0)});
      end
   endtask

   task automatic mid_reset(input int cyc);
      @(negedge clk) start = 1'b1;
      for (int c = 1; c <= cyc; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
      end
      check("pre_rst_busy", {busy}, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_idle("async_rst");
      @(negedge clk) check_idle("in_rst");
      rst_n = 1'b1;
   endtask

   initial begin
      build_ops();
      #23 check_idle("reset");
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) check_idle("idle");

      run_test(1'b0, 0);
      fault_en = 1'b1; fault_addr = 5; fault_bit = 0; fault_val = 1'b1;
      run_test(1'b0, 0);
      fault_en = 1'b0;
      run_test(1'b0, 0);
      run_test(1'b0, 50);
      mid_reset(80);
      run_test(1'b0, 0);

      for (int it = 0; it < 8; it++) begin
         fault_en   = ($urandom_range(0, 3) != 0);
         fault_addr = $urandom_range(0, N - 1);
         fault_bit  = $urandom_range(0, DW - 1);
         fault_val  = 1'($urandom_range(0, 1));
         run_test(1'b0, $urandom_range(2, 150));
      end

      fault_en = 1'b0;
      run_test(1'b1, 0);
      for (int it = 0; it < 2; it++) begin
         mid_reset($urandom_range(3, 155));
         run_test(1'b0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
